control_sequencer: RTL and testbench

Parametrised multicycle sequencing controller for `mips_cpu_bus`. It replaces the externally supplied `state` with an internal FSM that advances FETCH, DECODE, MEM and EXEC, and adds four things: Avalon `waitrequest` stalls, a configurable multi-cycle mult/div wait, bus-timeout and misalignment error halting, and a terminal HALT state. It drives the sequencing and strobe signals only. Datapath selects (`alu_op`, `rd_select`, `datamem_to_reg`, ...) stay in `control`, which takes this block's `state` output.

---
 rtl/control_sequencer_if.sv | 11 +
 rtl/control_sequencer.sv | 136 +++++++++++++
 tb/tb_control_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Avalon-style bus port between the sequencer and the memory interconnect.
interface control_sequencer_if;
    logic       read;
    logic       write;
    logic [3:0] byteenable;
    logic [4:0] write_data_sel;
    logic       waitrequest;

    modport master (output read, write, byteenable, write_data_sel, input waitrequest);
    modport slave  (input read, write, byteenable, write_data_sel, output waitrequest);
endinterface

// File: rtl/control_sequencer.sv
// Multicycle sequencer for mips_cpu_bus: FETCH/DECODE/MEM/EXEC with bus stalls,
// mult/div wait, timeout and misalignment halting.
module control_sequencer #(
    parameter int MULDIV_CYCLES = 4,
    parameter int WAIT_LIMIT    = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           function_code,
    input  logic [1:0]           byte_addressing,
    input  logic                 halt_req,
    control_sequencer_if.master  bus,
    output logic [2:0]           state,
    output logic                 ir_wren,
    output logic                 pc_wren,
    output logic                 reg_write_enable,
    output logic                 hi_wren,
    output logic                 lo_wren,
    output logic                 muldiv_start,
    output logic                 active,
    output logic                 bus_error
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, MEM = 3'd2, EXEC = 3'd3, MDWAIT = 3'd4, HALT = 3'd5
    } state_e;

    localparam int TW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [5:0] MD_LOAD = (MULDIV_CYCLES > 1) ? 6'(MULDIV_CYCLES - 2) : 6'd0;

    state_e        cur, nxt;
    logic [TW-1:0] wait_cnt;
    logic [5:0]    md_cnt;

    logic rd, wr, ir, pc, rwe, hw, lw, ms, err_set;
    logic [3:0] be;
    logic [4:0] sel;

    // Instruction classes
    logic rtype, is_load, is_store, is_muldiv, is_mthi, is_mtlo, is_regw, misalign;
    always_comb begin
        rtype     = (opcode == 6'd0);
        is_load   = (opcode >= 6'd32) && (opcode <= 6'd38);
        is_store  = (opcode == 6'd40) || (opcode == 6'd41) || (opcode == 6'd43);
        is_muldiv = rtype && (function_code >= 6'd24) && (function_code <= 6'd27);
        is_mthi   = rtype && (function_code == 6'd17);
        is_mtlo   = rtype && (function_code == 6'd19);
        is_regw   = (rtype && !(function_code == 6'd8) && !is_mthi && !is_mtlo && !is_muldiv)
                  || (opcode == 6'd3) || ((opcode >= 6'd9) && (opcode <= 6'd15)) || is_load;
        // LWL/LWR (34/38) merge partial words and are never misaligned
        misalign  = (((opcode == 6'd33) || (opcode == 6'd37) || (opcode == 6'd41)) && byte_addressing[0])
                  || (((opcode == 6'd35) || (opcode == 6'd43)) && (byte_addressing != 2'd0));
    end

    logic timeout;
    assign timeout = (WAIT_LIMIT != 0) && (wait_cnt == TW'(WAIT_LIMIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur       <= FETCH;
            wait_cnt  <= '0;
            md_cnt    <= '0;
            bus_error <= 1'b0;
        end else begin
            cur <= nxt;
            if ((rd || wr) && bus.waitrequest) wait_cnt <= wait_cnt + 1'b1;
            else                               wait_cnt <= '0;
            if (cur == MEM && nxt == MDWAIT) md_cnt <= MD_LOAD;
            else if (cur == MDWAIT)          md_cnt <= md_cnt - 6'd1;
            if (err_set) bus_error <= 1'b1;
        end
    end

    always_comb begin
        nxt = cur; rd = 1'b0; wr = 1'b0; be = 4'hF; sel = 5'd0;
        ir = 1'b0; pc = 1'b0; rwe = 1'b0; hw = 1'b0; lw = 1'b0; ms = 1'b0; err_set = 1'b0;
        case (cur)
            FETCH: begin
                rd = 1'b1;
                if (!bus.waitrequest) nxt = DECODE;
                else if (timeout) begin nxt = HALT; err_set = 1'b1; end
            end
            DECODE: begin
                ir  = 1'b1;
                nxt = MEM;
            end
            MEM: begin
                if (misalign) begin
                    err_set = 1'b1;
                    nxt     = HALT;
                end else if (is_load || is_store) begin
                    rd = is_load;
                    wr = is_store;
                    if (opcode == 6'd40) begin
                        be  = 4'b0001 << byte_addressing;
                        sel = 5'd1 + 5'(byte_addressing);
                    end else if (opcode == 6'd41) begin
                        be  = byte_addressing[1] ? 4'b1100 : 4'b0011;
                        sel = byte_addressing[1] ? 5'd6 : 5'd5;
                    end
                    if (!bus.waitrequest) nxt = EXEC;
                    else if (timeout) begin nxt = HALT; err_set = 1'b1; end
                end else if (is_muldiv) begin
                    ms  = 1'b1;
                    nxt = (MULDIV_CYCLES > 1) ? MDWAIT : EXEC;
                end else begin
                    nxt = EXEC;
                end
            end
            MDWAIT: if (md_cnt == 6'd0) nxt = EXEC;
            EXEC: begin
                pc  = 1'b1;
                rwe = is_regw;
                hw  = is_mthi || is_muldiv;
                lw  = is_mtlo || is_muldiv;
                nxt = halt_req ? HALT : FETCH;
            end
            HALT:    nxt = HALT;
            default: nxt = HALT;
        endcase
    end

    // Strobes are gated by reset so they drop immediately, even mid-access
    assign bus.read           = rd  && reset_n;
    assign bus.write          = wr  && reset_n;
    assign bus.byteenable     = reset_n ? be : 4'hF;
    assign bus.write_data_sel = reset_n ? sel : 5'd0;
    assign ir_wren            = ir  && reset_n;
    assign pc_wren            = pc  && reset_n;
    assign reg_write_enable   = rwe && reset_n;
    assign hi_wren            = hw  && reset_n;
    assign lo_wren            = lw  && reset_n;
    assign muldiv_start       = ms  && reset_n;
    assign active             = reset_n && (cur != HALT);
    assign state              = cur;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: two instances cover MULDIV_CYCLES 4/1 and
// WAIT_LIMIT 8/unlimited.
module tb_control_sequencer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode, function_code;
    logic [1:0] byte_addressing;
    logic       halt_req;

    always #5 clk = ~clk;

    control_sequencer_if bus_a ();
    control_sequencer_if bus_b ();

    logic [2:0] state_a, state_b;
    logic ir_a, pc_a, rwe_a, hi_a, lo_a, ms_a, active_a, err_a;
    logic ir_b, pc_b, rwe_b, hi_b, lo_b, ms_b, active_b, err_b;

    control_sequencer #(.MULDIV_CYCLES(4), .WAIT_LIMIT(8)) u_a (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .function_code(function_code),
        .byte_addressing(byte_addressing), .halt_req(halt_req), .bus(bus_a.master),
        .state(state_a), .ir_wren(ir_a), .pc_wren(pc_a), .reg_write_enable(rwe_a),
        .hi_wren(hi_a), .lo_wren(lo_a), .muldiv_start(ms_a), .active(active_a), .bus_error(err_a)
    );

    control_sequencer #(.MULDIV_CYCLES(1), .WAIT_LIMIT(0)) u_b (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .function_code(function_code),
        .byte_addressing(byte_addressing), .halt_req(halt_req), .bus(bus_b.master),
        .state(state_b), .ir_wren(ir_b), .pc_wren(pc_b), .reg_write_enable(rwe_b),
        .hi_wren(hi_b), .lo_wren(lo_b), .muldiv_start(ms_b), .active(active_b), .bus_error(err_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two cycles, check the reset state, release; returns in cycle 0 (FETCH)
    task automatic apply_reset(input logic [5:0] op, input logic [5:0] fn,
                               input logic [1:0] addr, input logic hr);
        opcode = op; function_code = fn; byte_addressing = addr; halt_req = hr;
        reset_n = 1'b0;
        bus_a.waitrequest = 1'b0;
        bus_b.waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_a), 32'd0);
        chk("rst_read", 32'(bus_a.read), 32'd0);
        chk("rst_active", 32'(active_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        reset_n = 1'b1;
        #1;
    endtask

    int exp_sa[8] = '{0, 1, 2, 4, 4, 4, 3, 0};
    int exp_ma[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    int exp_ha[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int exp_sb[5] = '{0, 1, 2, 3, 0};
    int exp_mb[5] = '{0, 0, 1, 0, 0};
    int exp_hb[5] = '{0, 0, 0, 1, 0};

    initial begin
        // ADDIU, zero wait
        apply_reset(6'd9, 6'd0, 2'd0, 1'b0);
        chk("rst_rel_be", 32'(bus_a.byteenable), 32'hF);
        chk("addiu_c0_state", 32'(state_a), 32'd0);
        chk("addiu_c0_read", 32'(bus_a.read), 32'd1);
        chk("addiu_c0_active", 32'(active_a), 32'd1);
        step();
        chk("addiu_c1_state", 32'(state_a), 32'd1);
        chk("addiu_c1_ir", 32'(ir_a), 32'd1);
        chk("addiu_c1_read", 32'(bus_a.read), 32'd0);
        step();
        chk("addiu_c2_state", 32'(state_a), 32'd2);
        chk("addiu_c2_ir", 32'(ir_a), 32'd0);
        chk("addiu_c2_read", 32'(bus_a.read), 32'd0);
        step();
        chk("addiu_c3_state", 32'(state_a), 32'd3);
        chk("addiu_c3_pc", 32'(pc_a), 32'd1);
        chk("addiu_c3_rwe", 32'(rwe_a), 32'd1);
        step();
        chk("addiu_c4_state", 32'(state_a), 32'd0);
        chk("addiu_c4_pc", 32'(pc_a), 32'd0);

        // SB at addr 2 with 3 stall cycles in MEM
        apply_reset(6'd40, 6'd0, 2'd2, 1'b0);
        step(); step();
        for (int i = 0; i < 4; i++) begin
            bus_a.waitrequest = (i < 3);
            chk($sformatf("sb_state%0d", i), 32'(state_a), 32'd2);
            chk($sformatf("sb_write%0d", i), 32'(bus_a.write), 32'd1);
            chk($sformatf("sb_be%0d", i), 32'(bus_a.byteenable), 32'h4);
            chk($sformatf("sb_sel%0d", i), 32'(bus_a.write_data_sel), 32'd3);
            step();
        end
        chk("sb_exec_state", 32'(state_a), 32'd3);
        chk("sb_exec_write", 32'(bus_a.write), 32'd0);
        chk("sb_exec_rwe", 32'(rwe_a), 32'd0);

        // MULT: 7 cycles with MULDIV_CYCLES=4, 4 cycles with MULDIV_CYCLES=1
        apply_reset(6'd0, 6'd24, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mult_a_state%0d", i), 32'(state_a), 32'(exp_sa[i]));
            chk($sformatf("mult_a_ms%0d", i), 32'(ms_a), 32'(exp_ma[i]));
            chk($sformatf("mult_a_hilo%0d", i), 32'({hi_a, lo_a}), 32'(exp_ha[i] * 3));
            if (i == 6) chk("mult_a_rwe", 32'(rwe_a), 32'd0);
            if (i < 5) begin
                chk($sformatf("mult_b_state%0d", i), 32'(state_b), 32'(exp_sb[i]));
                chk($sformatf("mult_b_ms%0d", i), 32'(ms_b), 32'(exp_mb[i]));
                chk($sformatf("mult_b_hilo%0d", i), 32'({hi_b, lo_b}), 32'(exp_hb[i] * 3));
            end
            step();
        end

        // Fetch timeout after 8 stall cycles
        apply_reset(6'd9, 6'd0, 2'd0, 1'b0);
        bus_a.waitrequest = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("to_fetch%0d", i), 32'({state_a, bus_a.read}), 32'({3'd0, 1'b1}));
            step();
        end
        chk("to_state", 32'(state_a), 32'd5);
        chk("to_err", 32'(err_a), 32'd1);
        chk("to_active", 32'(active_a), 32'd0);
        chk("to_read", 32'(bus_a.read), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("to_hold%0d", i), 32'({state_a, err_a, bus_a.read, active_a}),
                32'({3'd5, 1'b1, 1'b0, 1'b0}));
        end

        // Misaligned SH halts without a strobe
        apply_reset(6'd41, 6'd0, 2'd1, 1'b0);
        step(); step();
        chk("sh1_mem_state", 32'(state_a), 32'd2);
        chk("sh1_mem_write", 32'(bus_a.write), 32'd0);
        chk("sh1_mem_err", 32'(err_a), 32'd0);
        step();
        chk("sh1_state", 32'(state_a), 32'd5);
        chk("sh1_err", 32'(err_a), 32'd1);
        chk("sh1_write", 32'(bus_a.write), 32'd0);

        // Aligned SH upper half and SW
        apply_reset(6'd41, 6'd0, 2'd2, 1'b0);
        step(); step();
        chk("sh2_write", 32'(bus_a.write), 32'd1);
        chk("sh2_be", 32'(bus_a.byteenable), 32'hC);
        chk("sh2_sel", 32'(bus_a.write_data_sel), 32'd6);
        apply_reset(6'd43, 6'd0, 2'd0, 1'b0);
        step(); step();
        chk("sw_write", 32'(bus_a.write), 32'd1);
        chk("sw_be", 32'(bus_a.byteenable), 32'hF);
        chk("sw_sel", 32'(bus_a.write_data_sel), 32'd0);
        step();
        chk("sw_exec", 32'(state_a), 32'd3);

        // JR with halt_req
        apply_reset(6'd0, 6'd8, 2'd0, 1'b1);
        step(); step(); step();
        chk("jr_state", 32'(state_a), 32'd3);
        chk("jr_pc", 32'(pc_a), 32'd1);
        chk("jr_rwe", 32'(rwe_a), 32'd0);
        step();
        chk("jr_halt", 32'(state_a), 32'd5);
        chk("jr_active", 32'(active_a), 32'd0);
        chk("jr_pc_after", 32'(pc_a), 32'd0);

        // Reset asserted mid-store
        apply_reset(6'd43, 6'd0, 2'd0, 1'b0);
        step(); step();
        bus_a.waitrequest = 1'b1;
        chk("mid_write", 32'(bus_a.write), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_write", 32'(bus_a.write), 32'd0);
        chk("mid_rst_state", 32'(state_a), 32'd0);
        chk("mid_rst_be", 32'(bus_a.byteenable), 32'hF);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus_a.waitrequest = 1'b0;
        #1;
        chk("mid_rel_state", 32'(state_a), 32'd0);
        chk("mid_rel_read", 32'(bus_a.read), 32'd1);
        chk("mid_rel_err", 32'(err_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
